// File: rtl/run_step_controller_if.sv
// Board/core-facing signal bundle for the single-step controller.
// The master modport is the board/core side; the slave modport is the controller.
interface run_step_controller_if;
  logic        switchRun;
  logic [4:0]  SwitchSelector;
  logic [4:0]  core_rs_addr;
  logic [31:0] core_reg_data;
  logic        step_en;
  logic [4:0]  reg_read_addr_1;
  logic [31:0] reg_read_data_1;
  logic        halted;
  logic [31:0] step_count;

  modport master (
    output switchRun, SwitchSelector, core_rs_addr, core_reg_data,
    input  step_en, reg_read_addr_1, reg_read_data_1, halted, step_count
  );

  modport slave (
    input  switchRun, SwitchSelector, core_rs_addr, core_reg_data,
    output step_en, reg_read_addr_1, reg_read_data_1, halted, step_count
  );
endinterface

// File: rtl/run_step_controller.sv
// Single-step controller: debounces the run button into one core step per press,
// and owns register-file read port 1 for register browsing while halted.
module run_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned SETTLE_CYCLES   = 2
) (
  input  logic                  clkFast,
  input  logic                  reset,
  run_step_controller_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {HALT, STEP, SETTLE} state_t;

  state_t        state_q, state_d;
  logic          s1_q, s2_q;
  logic          stable_q, stable_d, stable_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   count_q, count_d;
  logic          rise;

  always_ff @(posedge clkFast or negedge reset) begin
    if (!reset) begin
      state_q       <= HALT;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
      settle_q      <= '0;
      data_q        <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      s1_q          <= bus.switchRun;
      s2_q          <= s1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
      settle_q      <= settle_d;
      data_q        <= data_d;
      count_q       <= count_d;
    end
  end

  // Any disagreement must persist DEBOUNCE_CYCLES edges; a single agreeing sample restarts it.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise = stable_q & ~stable_prev_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    data_d   = data_q;
    count_d  = count_q;
    unique case (state_q)
      HALT: begin
        data_d = bus.core_reg_data;
        if (rise) state_d = STEP;
      end
      STEP: begin
        state_d  = SETTLE;
        settle_d = '0;
        count_d  = count_q + 32'd1;
      end
      SETTLE: begin
        if (settle_q == SETTLE_MAX) state_d = HALT;
        else                        settle_d = settle_q + 1'b1;
      end
      default: state_d = HALT;
    endcase
  end

  assign bus.step_en         = (state_q == STEP);
  assign bus.halted          = (state_q == HALT);
  assign bus.reg_read_addr_1 = (state_q == HALT) ? bus.SwitchSelector : bus.core_rs_addr;
  assign bus.reg_read_data_1 = data_q;
  assign bus.step_count      = count_q;

endmodule

// File: tb/tb_run_step_controller.sv
// Directed testbench for run_step_controller with default parameters (D=8, settle=2).
module tb_run_step_controller;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   pulses;
  logic [31:0] exp_count;

  run_step_controller_if bus ();

  run_step_controller #(.DEBOUNCE_CYCLES(8), .SETTLE_CYCLES(2)) dut (
    .clkFast (clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file stand-in: r16 holds 0xA5, others a tagged copy of their index.
  function automatic logic [31:0] rf_model(input logic [4:0] a);
    return (a == 5'd16) ? 32'h0000_00A5 : (32'h1234_0000 | {27'd0, a});
  endfunction

  assign bus.core_reg_data = rf_model(bus.reg_read_addr_1);

  always @(negedge clk) if (bus.step_en === 1'b1) pulses++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press_edges(input int n);
    bus.switchRun = 1'b1;
    repeat (n) tick();
    bus.switchRun = 1'b0;
    repeat (25) tick();
  endtask

  task automatic wait_step(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus.step_en === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.switchRun = 1'b0;
    bus.SwitchSelector = 5'd0;
    bus.core_rs_addr = 5'd0;
    tick(); tick();
    vectors++; if (bus.step_en !== 1'b0) begin miscompares++; $display("FAIL reset_step_en got %b want 0", bus.step_en); end
    vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL reset_halted got %b want 1", bus.halted); end
    vectors++; if (bus.reg_read_data_1 !== 32'd0) begin miscompares++; $display("FAIL reset_data got %h want 0", bus.reg_read_data_1); end
    vectors++; if (bus.step_count !== 32'd0) begin miscompares++; $display("FAIL reset_count got %h want 0", bus.step_count); end
    reset = 1'b1;
    exp_count = 32'd0;
    repeat (3) tick();
  endtask

  task automatic test_clean_press;
    int p0;
    p0 = pulses;
    bus.switchRun = 1'b1;
    for (int e = 0; e < 16; e++) begin
      tick();
      vectors++;
      if (bus.step_en !== (e == 10)) begin
        miscompares++; $display("FAIL clean_step_en edge %0d got %b want %b", e, bus.step_en, (e == 10));
      end
      vectors++;
      if (bus.halted !== !(e >= 10 && e <= 12)) begin
        miscompares++; $display("FAIL clean_halted edge %0d got %b want %b", e, bus.halted, !(e >= 10 && e <= 12));
      end
    end
    bus.switchRun = 1'b0;
    repeat (20) tick();
    exp_count++;
    vectors++; if (bus.step_count !== exp_count) begin miscompares++; $display("FAIL clean_count got %h want %h", bus.step_count, exp_count); end
    vectors++; if (pulses !== p0 + 1) begin miscompares++; $display("FAIL clean_pulses got %0d want %0d", pulses - p0, 1); end
  endtask

  task automatic test_bounce;
    int p0;
    p0 = pulses;
    for (int i = 0; i < 30; i++) begin
      bus.switchRun = ((i / 3) % 2 == 0);
      tick();
    end
    bus.switchRun = 1'b0;
    repeat (20) tick();
    vectors++; if (pulses !== p0) begin miscompares++; $display("FAIL bounce_pulses got %0d want 0", pulses - p0); end
    vectors++; if (bus.step_count !== exp_count) begin miscompares++; $display("FAIL bounce_count got %h want %h", bus.step_count, exp_count); end
  endtask

  task automatic test_threshold;
    int p0;
    p0 = pulses;
    press_edges(7);
    vectors++; if (pulses !== p0) begin miscompares++; $display("FAIL thr7_pulses got %0d want 0", pulses - p0); end
    press_edges(8);
    exp_count++;
    vectors++; if (pulses !== p0 + 1) begin miscompares++; $display("FAIL thr8_pulses got %0d want 1", pulses - p0); end
    vectors++; if (bus.step_count !== exp_count) begin miscompares++; $display("FAIL thr8_count got %h want %h", bus.step_count, exp_count); end
    press_edges(500);
    exp_count++;
    vectors++; if (pulses !== p0 + 2) begin miscompares++; $display("FAIL hold500_pulses got %0d want 2", pulses - p0); end
    vectors++; if (bus.step_count !== exp_count) begin miscompares++; $display("FAIL hold500_count got %h want %h", bus.step_count, exp_count); end
  endtask

  task automatic test_browse;
    bit found;
    bus.SwitchSelector = 5'd3;
    #1;
    vectors++; if (bus.reg_read_addr_1 !== 5'd3) begin miscompares++; $display("FAIL browse_addr3 got %0d want 3", bus.reg_read_addr_1); end
    tick();
    vectors++; if (bus.reg_read_data_1 !== 32'h1234_0003) begin miscompares++; $display("FAIL browse_data3 got %h want 12340003", bus.reg_read_data_1); end
    bus.SwitchSelector = 5'd16;
    #1;
    vectors++; if (bus.reg_read_addr_1 !== 5'd16) begin miscompares++; $display("FAIL browse_addr16 got %0d want 16", bus.reg_read_addr_1); end
    tick();
    vectors++; if (bus.reg_read_data_1 !== 32'h0000_00A5) begin miscompares++; $display("FAIL browse_data16 got %h want 000000a5", bus.reg_read_data_1); end
    bus.core_rs_addr = 5'd7;
    bus.switchRun = 1'b1;
    wait_step(found);
    vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL browse_step_timeout got %b want 1", found); end
    vectors++; if (bus.reg_read_addr_1 !== 5'd7) begin miscompares++; $display("FAIL step_addr got %0d want 7", bus.reg_read_addr_1); end
    vectors++; if (bus.reg_read_data_1 !== 32'h0000_00A5) begin miscompares++; $display("FAIL step_data_hold got %h want 000000a5", bus.reg_read_data_1); end
    tick();
    vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL settle_halted got %b want 0", bus.halted); end
    vectors++; if (bus.reg_read_addr_1 !== 5'd7) begin miscompares++; $display("FAIL settle_addr got %0d want 7", bus.reg_read_addr_1); end
    vectors++; if (bus.reg_read_data_1 !== 32'h0000_00A5) begin miscompares++; $display("FAIL settle_data_hold got %h want 000000a5", bus.reg_read_data_1); end
    bus.switchRun = 1'b0;
    repeat (25) tick();
    exp_count++;
    vectors++; if (bus.step_count !== exp_count) begin miscompares++; $display("FAIL browse_count got %h want %h", bus.step_count, exp_count); end
  endtask

  task automatic test_reset_mid_step;
    bit found;
    int p0;
    bus.switchRun = 1'b1;
    wait_step(found);
    vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL midrst_step_timeout got %b want 1", found); end
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (bus.step_en !== 1'b0) begin miscompares++; $display("FAIL midrst_step_en got %b want 0", bus.step_en); end
    vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL midrst_halted got %b want 1", bus.halted); end
    vectors++; if (bus.step_count !== 32'd0) begin miscompares++; $display("FAIL midrst_count got %h want 0", bus.step_count); end
    vectors++; if (bus.reg_read_data_1 !== 32'd0) begin miscompares++; $display("FAIL midrst_data got %h want 0", bus.reg_read_data_1); end
    exp_count = 32'd0;
    bus.switchRun = 1'b0;
    tick();
    reset = 1'b1;
    p0 = pulses;
    repeat (30) tick();
    vectors++; if (pulses !== p0) begin miscompares++; $display("FAIL post_rst_pulses got %0d want 0", pulses - p0); end
    vectors++; if (bus.step_count !== 32'd0) begin miscompares++; $display("FAIL post_rst_count got %h want 0", bus.step_count); end
  endtask

  task automatic test_wrap;
    int p0;
    p0 = pulses;
    force dut.count_q = 32'hFFFF_FFFF;
    tick();
    release dut.count_q;
    tick();
    vectors++; if (bus.step_count !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_preload got %h want ffffffff", bus.step_count); end
    press_edges(10);
    vectors++; if (bus.step_count !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_count got %h want 00000000", bus.step_count); end
    vectors++; if (pulses !== p0 + 1) begin miscompares++; $display("FAIL wrap_pulses got %0d want 1", pulses - p0); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    pulses = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_threshold();
    test_browse();
    test_reset_mid_step();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
